// File: rtl/uart_transaction_sequencer.sv
// uart_transaction_sequencer: drives one ISO7816 command/response exchange
// over the UART register interface. It pushes the command bytes, waits for the
// line to drain, then collects the response under a per-character timeout.
//
// Host transmit handshake: a byte moves on the rising clk edge where txValid
// and txReady are both high. txReady never depends on txValid, and txValid may
// be held or dropped freely while txReady is low.
module uart_transaction_sequencer #(
    parameter int LEN_WIDTH     = 9,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     nReset,
    input  logic                     start,
    input  logic [LEN_WIDTH-1:0]     txLen,
    input  logic [LEN_WIDTH-1:0]     rxLen,
    input  logic [TIMEOUT_WIDTH-1:0] waitCycles,
    input  logic [7:0]               txByte,
    input  logic                     txValid,
    output logic                     txReady,
    output logic [7:0]               rxByte,
    output logic                     rxStrobe,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               result,
    output logic [7:0]               uartDataIn,
    output logic                     uartNWe,
    input  logic [7:0]               uartDataOut,
    output logic                     uartNCsDataOut,
    input  logic [7:0]               uartStatus,
    output logic                     uartNCsStatus,
    output logic [3:0]               dbgState
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_TX_LOAD, ST_TX_WRITE, ST_TX_CHECK, ST_TX_WAIT, ST_TX_DRAIN,
        ST_RX_ENTER, ST_RX_WAIT, ST_RX_READ, ST_RX_GAP, ST_DONE
    } state_t;

    localparam logic [1:0] RES_OK      = 2'd0;
    localparam logic [1:0] RES_TIMEOUT = 2'd1;
    localparam logic [1:0] RES_FRAME   = 2'd2;
    localparam logic [1:0] RES_OVERRUN = 2'd3;

    // UART status byte fields
    logic tx_run, tx_pending, is_tx, overrun, frame_err, buffer_full;
    assign tx_run      = uartStatus[7];
    assign tx_pending  = uartStatus[6];
    assign is_tx       = uartStatus[3];
    assign overrun     = uartStatus[2];
    assign frame_err   = uartStatus[1];
    assign buffer_full = uartStatus[0];

    // rxRun / rxStartBit carry no information this sequencer acts on
    logic unused_status;
    assign unused_status = ^uartStatus[5:4];

    state_t                   state_q, state_d;
    logic [LEN_WIDTH-1:0]     tx_cnt_q, tx_cnt_d;
    logic [LEN_WIDTH-1:0]     rx_cnt_q, rx_cnt_d;
    logic [TIMEOUT_WIDTH-1:0] wait_q, wait_d;
    logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [1:0]               result_q, result_d;
    logic [7:0]               rx_byte_q, rx_byte_d;
    logic                     rx_strobe_q, rx_strobe_d;
    logic [7:0]               data_in_q, data_in_d;
    logic                     nwe_q, nwe_d;
    logic                     ncs_data_q, ncs_data_d;
    logic                     ncs_status_q, ncs_status_d;
    logic                     finish;
    logic [1:0]               finish_code;

    // Never offer a byte while the UART still holds or is accepting one
    assign txReady = (state_q == ST_TX_LOAD) && !buffer_full && !tx_pending;

    assign rxByte         = rx_byte_q;
    assign rxStrobe       = rx_strobe_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign result         = result_q;
    assign uartDataIn     = data_in_q;
    assign uartNWe        = nwe_q;
    assign uartNCsDataOut = ncs_data_q;
    assign uartNCsStatus  = ncs_status_q;
    assign dbgState       = state_q;

    // Next-state and registered-output decode
    always_comb begin
        state_d     = state_q;
        tx_cnt_d    = tx_cnt_q;
        rx_cnt_d    = rx_cnt_q;
        wait_d      = wait_q;
        tmo_d       = tmo_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        result_d    = result_q;
        rx_byte_d   = rx_byte_q;
        rx_strobe_d = 1'b0;
        data_in_d   = data_in_q;
        nwe_d       = 1'b1;
        ncs_data_d  = 1'b1;
        finish      = 1'b0;
        finish_code = RES_OK;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tx_cnt_d = txLen;
                    rx_cnt_d = rxLen;
                    wait_d   = waitCycles;
                    busy_d   = 1'b1;
                    if (txLen != '0)      state_d = ST_TX_LOAD;
                    else if (rxLen != '0) state_d = ST_RX_ENTER;
                    else                  finish  = 1'b1;
                end
            end
            ST_TX_LOAD: begin
                if (txValid && txReady) begin
                    data_in_d = txByte;
                    nwe_d     = 1'b0;
                    state_d   = ST_TX_WRITE;
                end
            end
            ST_TX_WRITE: begin
                state_d = ST_TX_CHECK;
            end
            ST_TX_CHECK: begin
                // No pending flag means the write was swallowed by a flag
                // acknowledge; rewrite the held byte once the buffer is free.
                if (tx_pending) begin
                    state_d = ST_TX_WAIT;
                end else if (!buffer_full) begin
                    nwe_d   = 1'b0;
                    state_d = ST_TX_WRITE;
                end
            end
            ST_TX_WAIT: begin
                if (!tx_pending) begin
                    if (tx_cnt_q != '0) tx_cnt_d = tx_cnt_q - LEN_WIDTH'(1);
                    state_d = (tx_cnt_q > LEN_WIDTH'(1)) ? ST_TX_LOAD : ST_TX_DRAIN;
                end
            end
            ST_TX_DRAIN: begin
                if (!tx_run && !tx_pending) begin
                    if (rx_cnt_q != '0) state_d = ST_RX_ENTER;
                    else                finish  = 1'b1;
                end
            end
            ST_RX_ENTER: begin
                tmo_d   = wait_q;
                state_d = ST_RX_WAIT;
            end
            ST_RX_WAIT: begin
                if (buffer_full && !is_tx) begin
                    ncs_data_d = 1'b0;
                    state_d    = ST_RX_READ;
                end else if ((wait_q != '0) && (tmo_q == '0)) begin
                    finish      = 1'b1;
                    finish_code = RES_TIMEOUT;
                end else if (tmo_q != '0) begin
                    tmo_d = tmo_q - TIMEOUT_WIDTH'(1);
                end
            end
            ST_RX_READ: begin
                if (overrun) begin
                    finish      = 1'b1;
                    finish_code = RES_OVERRUN;
                end else if (frame_err) begin
                    finish      = 1'b1;
                    finish_code = RES_FRAME;
                end else begin
                    rx_byte_d   = uartDataOut;
                    rx_strobe_d = 1'b1;
                    if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - LEN_WIDTH'(1);
                    state_d     = ST_RX_GAP;
                end
            end
            ST_RX_GAP: begin
                // Gives bufferFull a cycle to fall after the read strobe
                if (rx_cnt_q != '0) begin
                    tmo_d   = wait_q;
                    state_d = ST_RX_WAIT;
                end else begin
                    finish = 1'b1;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (finish) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = finish_code;
        end

        ncs_status_d = ~busy_d;
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q      <= ST_IDLE;
            tx_cnt_q     <= '0;
            rx_cnt_q     <= '0;
            wait_q       <= '0;
            tmo_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= RES_OK;
            rx_byte_q    <= 8'h00;
            rx_strobe_q  <= 1'b0;
            data_in_q    <= 8'h00;
            nwe_q        <= 1'b1;
            ncs_data_q   <= 1'b1;
            ncs_status_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            tx_cnt_q     <= tx_cnt_d;
            rx_cnt_q     <= rx_cnt_d;
            wait_q       <= wait_d;
            tmo_q        <= tmo_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            result_q     <= result_d;
            rx_byte_q    <= rx_byte_d;
            rx_strobe_q  <= rx_strobe_d;
            data_in_q    <= data_in_d;
            nwe_q        <= nwe_d;
            ncs_data_q   <= ncs_data_d;
            ncs_status_q <= ncs_status_d;
        end
    end

endmodule

// File: tb/tb_uart_transaction_sequencer.sv
// Bench for uart_transaction_sequencer: a behavioural UART register model,
// a host byte driver, an output monitor and a directed/random test sequence.
module tb_uart_transaction_sequencer;

    logic       clk = 1'b0;
    logic       nReset;
    logic       start;
    logic [8:0] txLen, rxLen;
    logic [15:0] waitCycles;
    logic [7:0] txByte;
    logic       txValid;
    logic       txReady;
    logic [7:0] rxByte;
    logic       rxStrobe, busy, done;
    logic [1:0] result;
    logic [7:0] uartDataIn;
    logic       uartNWe;
    logic [7:0] uartDataOut;
    logic       uartNCsDataOut;
    logic [7:0] uartStatus;
    logic       uartNCsStatus;
    logic [3:0] dbg_state;

    uart_transaction_sequencer #(.LEN_WIDTH(9), .TIMEOUT_WIDTH(16)) dut (
        .clk(clk), .nReset(nReset), .start(start), .txLen(txLen), .rxLen(rxLen),
        .waitCycles(waitCycles), .txByte(txByte), .txValid(txValid), .txReady(txReady),
        .rxByte(rxByte), .rxStrobe(rxStrobe), .busy(busy), .done(done), .result(result),
        .uartDataIn(uartDataIn), .uartNWe(uartNWe), .uartDataOut(uartDataOut),
        .uartNCsDataOut(uartNCsDataOut), .uartStatus(uartStatus),
        .uartNCsStatus(uartNCsStatus), .dbgState(dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];      // bytes the UART must receive, in order
    logic [7:0] exp_rx_q[$];   // bytes the host must see strobed
    logic [7:0] tx_src[$];     // host stream still to be offered
    logic [7:0] uart_tx_q[$];  // bytes the UART model actually accepted
    logic [7:0] got_rx_q[$];   // bytes strobed by the DUT
    logic [9:0] rx_src[$];     // {overrun, frameErr, data} the UART will deliver
    logic [7:0] tx_plan[$];
    logic [9:0] rx_plan[$];

    int hs_count    = 0;
    int done_count  = 0;
    int read_count  = 0;
    int collide_cnt = 0;
    int rx_gate_n   = 0;
    int cycle       = 0;

    // UART model state
    logic tx_pend, tx_run, buf_full, rx_fe, rx_ov;
    logic [7:0] rx_data;
    int pend_cnt, run_cnt, gap_cnt;

    assign uartStatus  = {tx_run, tx_pend, 1'b0, 1'b0, tx_run | tx_pend, rx_ov, rx_fe, buf_full};
    assign uartDataOut = rx_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check(tag,
              {28'd0, txReady, rxStrobe, done, busy},
              32'd0);
        check({tag, ":data"},
              {6'd0, result, rxByte, uartDataIn, uartNWe, uartNCsDataOut, uartNCsStatus, dbg_state, 1'b0},
              {6'd0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0});
    endtask

    // UART register model: accepts writes (unless an acknowledge collision is
    // scheduled), shifts them out, then answers with the planned rx bytes.
    initial begin
        logic wr, rd;
        logic [7:0] wd;
        logic [9:0] e;
        tx_pend = 0; tx_run = 0; buf_full = 0; rx_fe = 0; rx_ov = 0; rx_data = 8'h00;
        pend_cnt = 0; run_cnt = 0; gap_cnt = 3;
        forever begin
            @(negedge clk);
            wr = nReset && !uartNWe;
            wd = uartDataIn;
            rd = nReset && !uartNCsDataOut;
            @(posedge clk);
            #1;
            if (!nReset) begin
                tx_pend = 0; tx_run = 0; buf_full = 0; rx_fe = 0; rx_ov = 0;
                pend_cnt = 0; run_cnt = 0; gap_cnt = 3;
            end else begin
                if (wr) begin
                    if (collide_cnt > 0) begin
                        collide_cnt--;
                    end else begin
                        uart_tx_q.push_back(wd);
                        tx_pend  = 1;
                        pend_cnt = $urandom_range(1, 4);
                    end
                end else if (tx_pend) begin
                    if (pend_cnt == 0) begin
                        tx_pend = 0;
                        tx_run  = 1;
                        run_cnt = $urandom_range(3, 8);
                    end else begin
                        pend_cnt--;
                    end
                end else if (tx_run) begin
                    if (run_cnt == 0) tx_run = 0;
                    else run_cnt--;
                end
                if (rd) begin
                    buf_full = 0; rx_fe = 0; rx_ov = 0;
                    gap_cnt  = $urandom_range(2, 10);
                end else if (!buf_full && rx_src.size() > 0 && uart_tx_q.size() >= rx_gate_n
                             && !tx_run && !tx_pend) begin
                    if (gap_cnt == 0) begin
                        e = rx_src.pop_front();
                        rx_data  = e[7:0];
                        rx_fe    = e[8];
                        rx_ov    = e[9];
                        buf_full = 1;
                    end else begin
                        gap_cnt--;
                    end
                end
            end
        end
    end

    // Host driver: offers tx_src bytes with random valid gaps
    initial begin
        logic fire;
        txValid = 0;
        txByte  = 8'h00;
        forever begin
            @(negedge clk);
            fire = nReset && txValid && txReady;
            @(posedge clk);
            #1;
            if (fire && tx_src.size() > 0) begin
                void'(tx_src.pop_front());
                hs_count++;
            end
            if (tx_src.size() > 0) begin
                txValid = ($urandom_range(0, 3) != 0);
                txByte  = tx_src[0];
            end else begin
                txValid = 0;
            end
        end
    end

    // Output monitor and bus-rule checks
    initial begin
        forever begin
            @(negedge clk);
            cycle++;
            if (nReset) begin
                if (rxStrobe) got_rx_q.push_back(rxByte);
                if (done) done_count++;
                if (!uartNCsDataOut) read_count++;
                check("nwe_ncs_exclusive", {31'd0, !uartNWe && !uartNCsDataOut}, 32'd0);
                check("txready_guard", {31'd0, txReady && (buf_full || tx_pend)}, 32'd0);
                if (!uartNWe) check("write_when_full", {31'd0, buf_full}, 32'd0);
            end
        end
    end

    // One full transaction from tx_plan/rx_plan, checked against the reference
    task automatic run_txn(input string name, input int tl, input int rl, input int wc,
                           input bit poke_busy, output int lat);
        int exp_res, exp_reads, start_cycle;
        bit got_done;
        logic [9:0] e;
        // Reference: results follow from the planned UART responses alone
        exp_q.delete();
        exp_rx_q.delete();
        foreach (tx_plan[i]) exp_q.push_back(tx_plan[i]);
        exp_res = 0;
        exp_reads = 0;
        for (int i = 0; i < rl; i++) begin
            if (i >= rx_plan.size()) begin exp_res = 1; break; end
            e = rx_plan[i];
            exp_reads++;
            if (e[9]) begin exp_res = 3; break; end
            if (e[8]) begin exp_res = 2; break; end
            exp_rx_q.push_back(e[7:0]);
        end

        @(posedge clk);
        #1;
        hs_count = 0; done_count = 0; read_count = 0;
        uart_tx_q.delete();
        got_rx_q.delete();
        rx_gate_n = tl;
        foreach (rx_plan[i]) rx_src.push_back(rx_plan[i]);
        foreach (tx_plan[i]) tx_src.push_back(tx_plan[i]);
        start = 1; txLen = 9'(tl); rxLen = 9'(rl); waitCycles = 16'(wc);
        start_cycle = cycle + 1;
        @(posedge clk);
        #1;
        start = 0;
        txLen = 9'($urandom_range(0, 511));
        rxLen = 9'($urandom_range(0, 511));
        waitCycles = 16'($urandom_range(0, 65535));
        if (poke_busy) begin
            repeat (2) @(posedge clk);
            #1;
            check({name, ":busy_mid"}, {31'd0, busy}, 32'd1);
            start = 1; txLen = 9'd7; rxLen = 9'd0; waitCycles = 16'd5;
            @(posedge clk);
            #1;
            start = 0;
        end

        got_done = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (done) begin got_done = 1; break; end
        end
        #1;
        lat = cycle - start_cycle;
        check({name, ":done_seen"}, {31'd0, got_done}, 32'd1);
        check({name, ":result"}, {30'd0, result}, 32'(exp_res));
        check({name, ":busy_at_done"}, {31'd0, busy}, 32'd1);
        check({name, ":line_idle_at_done"}, {30'd0, tx_run, tx_pend}, 32'd0);
        @(negedge clk);
        check({name, ":busy_after"}, {29'd0, busy, done, !uartNCsStatus}, 32'd0);
        check({name, ":result_held"}, {30'd0, result}, 32'(exp_res));
        repeat (4) @(negedge clk);
        #1;
        check({name, ":done_count"}, 32'(done_count), 32'd1);
        check({name, ":handshakes"}, 32'(hs_count), 32'(tl));
        check({name, ":reads"}, 32'(read_count), 32'(exp_reads));
        check({name, ":tx_size"}, 32'(uart_tx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < uart_tx_q.size(); i++)
            check({name, ":tx_byte"}, {24'd0, uart_tx_q[i]}, {24'd0, exp_q[i]});
        check({name, ":rx_size"}, 32'(got_rx_q.size()), 32'(exp_rx_q.size()));
        for (int i = 0; i < exp_rx_q.size() && i < got_rx_q.size(); i++)
            check({name, ":rx_byte"}, {24'd0, got_rx_q[i]}, {24'd0, exp_rx_q[i]});
        tx_src.delete();
        rx_src.delete();
    endtask

    initial begin
        int lat, tl, rl, n_avail, f;
        bit hit;
        nReset = 0; start = 0; txLen = 0; rxLen = 0; waitCycles = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        nReset = 1;
        repeat (2) @(posedge clk);

        // 1: five command bytes, no response
        tx_plan = '{8'h00, 8'hA0, 8'h04, 8'h00, 8'h02};
        rx_plan = {};
        run_txn("t1_tx5", 5, 0, 50, 0, lat);

        // 2: one byte out, two back, timeout disabled; a start while busy is ignored
        tx_plan = '{8'h88};
        rx_plan = '{10'h090, 10'h000};
        run_txn("t2_tx1_rx2", 1, 2, 0, 1, lat);

        // 3: nothing arrives, timeout after waitCycles
        tx_plan = {};
        rx_plan = {};
        run_txn("t3_timeout", 0, 1, 100, 0, lat);
        check("t3_timeout_latency_ok", {31'd0, (lat - 1 >= 100) && (lat - 1 <= 102)}, 32'd1);

        // 4: frame error then overrun on the second response byte
        tx_plan = '{8'h5C};
        rx_plan = '{10'h0A5, 10'h13C};
        run_txn("t4_frame", 1, 2, 60, 0, lat);
        tx_plan = '{8'h3E};
        rx_plan = '{10'h0C3, 10'h277};
        run_txn("t4_overrun", 1, 3, 60, 0, lat);

        // empty exchange completes immediately and clears the held error
        tx_plan = {};
        rx_plan = {};
        run_txn("t_empty", 0, 0, 10, 0, lat);

        // 5: two writes swallowed by acknowledge collisions
        tx_plan = '{8'h11, 8'h22, 8'h33};
        rx_plan = '{10'h061};
        collide_cnt = 2;
        run_txn("t5_collide", 3, 1, 80, 0, lat);
        check("t5_collisions_consumed", 32'(collide_cnt), 32'd0);

        // random exchanges
        for (int k = 0; k < 8; k++) begin
            tl = $urandom_range(0, 6);
            rl = $urandom_range(0, 5);
            tx_plan = {};
            rx_plan = {};
            for (int i = 0; i < tl; i++) tx_plan.push_back(8'($urandom_range(0, 255)));
            n_avail = ($urandom_range(0, 3) == 0) ? $urandom_range(0, rl) : rl;
            for (int i = 0; i < n_avail; i++) begin
                f = $urandom_range(0, 9);
                rx_plan.push_back({f == 1, f == 0, 8'($urandom_range(0, 255))});
                if (f <= 1) break;
            end
            run_txn("t_rand", tl, rl, $urandom_range(40, 200), 0, lat);
        end

        // 6: reset while waiting for the UART to accept a byte
        tx_plan = {};
        rx_plan = {};
        @(posedge clk);
        #1;
        uart_tx_q.delete();
        tx_src.push_back(8'hA1); tx_src.push_back(8'hA2); tx_src.push_back(8'hA3);
        start = 1; txLen = 9'd3; rxLen = 9'd0; waitCycles = 16'd50;
        @(posedge clk);
        #1;
        start = 0;
        hit = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_pend) begin hit = 1; break; end
        end
        check("t6_reached_tx_wait", {31'd0, hit}, 32'd1);
        @(posedge clk);
        #2;
        nReset = 0;
        #1;
        check_reset_values("t6_reset");
        done_count = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("t6_reset_hold");
        tx_src.delete();
        uart_tx_q.delete();
        collide_cnt = 0;
        nReset = 1;
        repeat (20) @(negedge clk);
        check("t6_no_stale_done", 32'(done_count), 32'd0);
        tx_plan = '{8'h7E};
        rx_plan = {};
        run_txn("t6_after_reset", 1, 0, 30, 0, lat);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_transaction_sequencer.md
Name: uart_transaction_sequencer

Overview:
- Sequences one ISO7816 command/response exchange over the half-duplex UART register interface.
- Per start: pushes txLen bytes from a host stream into the UART, waits for the line to go idle, then collects rxLen bytes under a character waiting-time timeout.
- Reports completion with a result code.
- Sits between the protocol layer (T=0/T=1 logic) and the UART interface block; it is that block's only bus master.

Parameters:
LEN_WIDTH, 9, width of txLen/rxLen byte counts (0..511)
TIMEOUT_WIDTH, 16, width of waitCycles and the timeout counter

Ports:
clk  in  1  system clock, all logic on rising edge
nReset  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only when busy=0
txLen  in  LEN_WIDTH  bytes to send; sampled with start
rxLen  in  LEN_WIDTH  bytes to receive; sampled with start
waitCycles  in  TIMEOUT_WIDTH  per-character receive timeout in clk cycles; 0 disables it; sampled with start
txByte  in  8  host transmit data
txValid  in  1  txByte valid
txReady  out  1  transfer when txValid&txReady
rxByte  out  8  received byte, valid with rxStrobe
rxStrobe  out  1  one-cycle pulse per received byte; no backpressure
busy  out  1  transaction in progress
done  out  1  one-cycle completion pulse
result  out  2  0 OK, 1 timeout, 2 frame/parity error, 3 overrun; held until next done
uartDataIn  out  8  to UART dataIn
uartNWe  out  1  to UART nWeDataIn, active low
uartDataOut  in  8  from UART dataOut
uartNCsDataOut  out  1  to UART nCsDataOut, active low
uartStatus  in  8  {txRun,txPending,rxRun,rxStartBit,isTx,overrun,frameErr,bufferFull}
uartNCsStatus  out  1  to UART nCsStatusOut; low while busy

Behaviour:
- Reset (async): state IDLE; txReady=0, rxStrobe=0, done=0, busy=0, result=0, rxByte=0, uartDataIn=0, uartNWe=1, uartNCsDataOut=1, uartNCsStatus=1, counters=0.
- All outputs are registered except txReady, which is a combinational decode of state and status.
- IDLE: on start, latch txLen/rxLen/waitCycles; busy=1 next cycle. start while busy is ignored.
- Next state after IDLE: txLen>0 -> TX_LOAD; else rxLen>0 -> RX_ENTER; else DONE (OK).
- TX_LOAD: txReady=1 only while bufferFull=0 and txPending=0.
  - On transfer: uartDataIn<=txByte, go TX_WRITE.
- TX_WRITE: uartNWe=0 for exactly one cycle, then TX_CHECK.
- TX_CHECK (status reflects the write this cycle):
  - txPending=1 -> TX_WAIT.
  - Else retry: TX_WRITE again with the same byte (the write was shadowed by a UART flag acknowledge).
  - Bytes are never lost or duplicated.
- TX_WAIT: wait txPending=0 (byte accepted by the UART), then decrement the tx count.
  - Count >0 -> TX_LOAD.
  - Else -> TX_DRAIN.
- TX_DRAIN: wait txRun=0 and txPending=0.
  - rxLen>0 -> RX_ENTER.
  - Else -> DONE(OK).
- RX_ENTER: reload the timeout counter with waitCycles, go RX_WAIT.
- RX_WAIT, checked in priority order each cycle:
  - bufferFull=1 and isTx=0 -> RX_READ.
  - Else if waitCycles≠0 and counter=0 -> DONE(timeout).
  - Else decrement the counter if nonzero.
- RX_READ: uartNCsDataOut=0 for one cycle.
  - Same cycle: capture uartDataOut and flags.
  - overrun=1 -> DONE(3).
  - Else frameErr=1 -> DONE(2).
  - Else rxByte<=data, rxStrobe pulses next cycle, decrement the rx count.
  - Then RX_GAP.
- RX_GAP: one cycle so bufferFull reflects the read.
  - Count >0 -> reload the timeout, RX_WAIT.
  - Else -> DONE(OK).
- DONE: done=1 and result updated for one cycle; busy=0 on the following cycle; -> IDLE.
- Erroneous bytes are not strobed to the host. After an error, any remaining tx/rx bytes are abandoned.
- Counters: tx/rx counts are LEN_WIDTH bits, decrement only, no wrap. The timeout counter saturates at 0.
- The UART is never written while bufferFull=1. uartNWe and uartNCsDataOut are never both low.
- Reset mid-transaction: immediate return to reset values. No done pulse; the host restarts.

Test Plan:
1. txLen=5 bytes 0x00,0xA0,0x04,0x00,0x02, rxLen=0 -> five uartNWe pulses with those bytes in order, done with result=0 only after txRun=0.
2. txLen=1 (0x88), rxLen=2, UART model returns 0x90,0x00 -> rxStrobe twice with 0x90 then 0x00, done result=0, two uartNCsDataOut pulses.
3. txLen=0, rxLen=1, waitCycles=100, no rx -> done result=1 exactly 101±1 cycles after RX_ENTER, no rxStrobe.
4. Second rx byte arrives with frameErr=1 -> first byte strobed, done result=2, second byte not strobed; repeat with overrun=1 -> result=3.
5. UART acknowledge collides with the write cycle (txPending stays 0) -> sequencer rewrites the same byte, receiver sees each byte exactly once, txValid/txReady handshake count equals txLen.
6. Assert nReset in TX_WAIT, then start a new 1-byte transaction -> all outputs at reset values during reset, new transaction completes with result=0, no stale done.
